// File: rtl/cic_d_mc.sv
// cic_d_mc: multi-channel, time-interleaved CIC decimator with runtime rate and output shift.
// Build option CIC_D_MC_ROUND_EN: round half up before the output shift instead of truncating.
module cic_d_mc #(
    parameter int unsigned INP_DW    = 16,
    parameter int unsigned OUT_DW    = 16,
    parameter int unsigned CIC_N     = 3,
    parameter int unsigned CIC_M     = 1,
    parameter int unsigned CIC_R_MAX = 16,
    parameter int unsigned NUM_CH    = 2,
    localparam int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int unsigned B_MAX    = INP_DW + CIC_N * $clog2(CIC_R_MAX * CIC_M),
    localparam int unsigned RATE_W   = $clog2(CIC_R_MAX + 1),
    localparam int unsigned SHIFT_W  = $clog2(B_MAX)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [RATE_W-1:0]        cfg_rate,
    input  logic [SHIFT_W-1:0]       cfg_shift,
    input  logic                     cfg_load,
    input  logic signed [INP_DW-1:0] s_axis_in_tdata,
    input  logic [CH_W-1:0]          s_axis_in_tuser,
    input  logic                     s_axis_in_tvalid,
    output logic signed [OUT_DW-1:0] m_axis_out_tdata,
    output logic [CH_W-1:0]          m_axis_out_tuser,
    output logic                     m_axis_out_tvalid
);

    localparam logic signed [OUT_DW-1:0] OUT_MAX = {1'b0, {(OUT_DW-1){1'b1}}};
    localparam logic signed [OUT_DW-1:0] OUT_MIN = {1'b1, {(OUT_DW-1){1'b0}}};
    localparam logic signed [B_MAX:0]    SAT_HI  = (B_MAX+1)'(OUT_MAX);
    localparam logic signed [B_MAX:0]    SAT_LO  = (B_MAX+1)'(OUT_MIN);

    logic              clr_c;
    logic              tag_ok_c;
    logic              in_ok_c;
    logic [RATE_W-1:0] rate_c;
    logic [RATE_W-1:0] rate_q;
    logic [SHIFT_W-1:0] shift_q;

    // reset and cfg_load share one flush; only reset touches the configuration
    assign clr_c = reset | cfg_load;

    if (NUM_CH < (1 << CH_W)) begin : g_tag_chk
        assign tag_ok_c = {1'b0, s_axis_in_tuser} < (CH_W+1)'(NUM_CH);
    end else begin : g_tag_all
        assign tag_ok_c = 1'b1;
    end

    assign in_ok_c = s_axis_in_tvalid & tag_ok_c & ~cfg_load;

    always_comb begin
        rate_c = cfg_rate;
        if (cfg_rate == '0) begin
            rate_c = RATE_W'(1);
        end else if (cfg_rate > RATE_W'(CIC_R_MAX)) begin
            rate_c = RATE_W'(CIC_R_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rate_q  <= RATE_W'(1);
            shift_q <= '0;
        end else if (cfg_load) begin
            rate_q  <= rate_c;
            shift_q <= cfg_shift;
        end
    end

    // ---------------- integrators ----------------
    logic signed [B_MAX-1:0] acc       [CIC_N][NUM_CH];
    logic signed [B_MAX-1:0] int_data  [CIC_N];
    logic [CH_W-1:0]         int_ch    [CIC_N];
    logic                    int_vld   [CIC_N];
    logic signed [B_MAX-1:0] int_din_c [CIC_N];
    logic [CH_W-1:0]         int_dch_c [CIC_N];
    logic                    int_dv_c  [CIC_N];
    logic signed [B_MAX-1:0] int_sum_c [CIC_N];

    always_comb begin
        int_din_c[0] = B_MAX'(s_axis_in_tdata);
        int_dch_c[0] = s_axis_in_tuser;
        int_dv_c[0]  = in_ok_c;
        for (int k = 1; k < CIC_N; k++) begin
            int_din_c[k] = int_data[k-1];
            int_dch_c[k] = int_ch[k-1];
            int_dv_c[k]  = int_vld[k-1];
        end
        for (int k = 0; k < CIC_N; k++) begin
            int_sum_c[k] = acc[k][int_dch_c[k]] + int_din_c[k];
        end
    end

    // each stage owns its accumulator bank, so same-channel samples back to back are safe
    always_ff @(posedge clk) begin
        if (clr_c) begin
            for (int k = 0; k < CIC_N; k++) begin
                int_vld[k]  <= 1'b0;
                int_data[k] <= '0;
                int_ch[k]   <= '0;
                for (int c = 0; c < NUM_CH; c++) begin
                    acc[k][c] <= '0;
                end
            end
        end else begin
            for (int k = 0; k < CIC_N; k++) begin
                int_vld[k] <= int_dv_c[k];
                if (int_dv_c[k]) begin
                    acc[k][int_dch_c[k]] <= int_sum_c[k];
                    int_data[k]          <= int_sum_c[k];
                    int_ch[k]            <= int_dch_c[k];
                end
            end
        end
    end

    // ---------------- decimator ----------------
    logic [RATE_W-1:0] cnt [NUM_CH];
    logic              dec_pass_c;

    assign dec_pass_c = int_vld[CIC_N-1] &&
                        (cnt[int_ch[CIC_N-1]] == rate_q - RATE_W'(1));

    always_ff @(posedge clk) begin
        if (clr_c) begin
            for (int c = 0; c < NUM_CH; c++) begin
                cnt[c] <= '0;
            end
        end else if (int_vld[CIC_N-1]) begin
            cnt[int_ch[CIC_N-1]] <= dec_pass_c ? '0 : cnt[int_ch[CIC_N-1]] + RATE_W'(1);
        end
    end

    // ---------------- combs ----------------
    logic signed [B_MAX-1:0] dly       [CIC_N][NUM_CH][CIC_M];
    logic signed [B_MAX-1:0] cmb_data  [CIC_N];
    logic [CH_W-1:0]         cmb_ch    [CIC_N];
    logic                    cmb_vld   [CIC_N];
    logic signed [B_MAX-1:0] cmb_din_c [CIC_N];
    logic [CH_W-1:0]         cmb_dch_c [CIC_N];
    logic                    cmb_dv_c  [CIC_N];

    always_comb begin
        cmb_din_c[0] = int_data[CIC_N-1];
        cmb_dch_c[0] = int_ch[CIC_N-1];
        cmb_dv_c[0]  = dec_pass_c;
        for (int k = 1; k < CIC_N; k++) begin
            cmb_din_c[k] = cmb_data[k-1];
            cmb_dch_c[k] = cmb_ch[k-1];
            cmb_dv_c[k]  = cmb_vld[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (clr_c) begin
            for (int k = 0; k < CIC_N; k++) begin
                cmb_vld[k]  <= 1'b0;
                cmb_data[k] <= '0;
                cmb_ch[k]   <= '0;
                for (int c = 0; c < NUM_CH; c++) begin
                    for (int m = 0; m < CIC_M; m++) begin
                        dly[k][c][m] <= '0;
                    end
                end
            end
        end else begin
            for (int k = 0; k < CIC_N; k++) begin
                cmb_vld[k] <= cmb_dv_c[k];
                if (cmb_dv_c[k]) begin
                    cmb_data[k]                <= cmb_din_c[k] - dly[k][cmb_dch_c[k]][CIC_M-1];
                    cmb_ch[k]                  <= cmb_dch_c[k];
                    dly[k][cmb_dch_c[k]][0]    <= cmb_din_c[k];
                    for (int m = 1; m < CIC_M; m++) begin
                        dly[k][cmb_dch_c[k]][m] <= dly[k][cmb_dch_c[k]][m-1];
                    end
                end
            end
        end
    end

    // ---------------- scale and saturate ----------------
    logic signed [B_MAX:0]      wide_c;
    logic signed [B_MAX:0]      shr_c;
    logic signed [B_MAX:0]      res_c;
    logic                       rnd_bit_c;
    logic signed [OUT_DW-1:0]   sat_c;
`ifdef CIC_D_MC_ROUND_EN
    logic signed [B_MAX:0]      rnd_c;
`endif

    // rounding adds the last bit shifted out, equal to adding 2^(shift-1) before the shift
    always_comb begin
        wide_c = (B_MAX+1)'(cmb_data[CIC_N-1]);
        shr_c  = wide_c >>> shift_q;
`ifdef CIC_D_MC_ROUND_EN
        rnd_c     = wide_c >>> (shift_q - SHIFT_W'(1));
        rnd_bit_c = (shift_q != '0) & rnd_c[0];
`else
        rnd_bit_c = 1'b0;
`endif
        res_c = shr_c + $signed({{B_MAX{1'b0}}, rnd_bit_c});
        if (res_c > SAT_HI) begin
            sat_c = OUT_MAX;
        end else if (res_c < SAT_LO) begin
            sat_c = OUT_MIN;
        end else begin
            sat_c = OUT_DW'(res_c);
        end
    end

    always_ff @(posedge clk) begin
        if (clr_c) begin
            m_axis_out_tvalid <= 1'b0;
            m_axis_out_tdata  <= '0;
            m_axis_out_tuser  <= '0;
        end else begin
            m_axis_out_tvalid <= cmb_vld[CIC_N-1];
            if (cmb_vld[CIC_N-1]) begin
                m_axis_out_tdata <= sat_c;
                m_axis_out_tuser <= cmb_ch[CIC_N-1];
            end
        end
    end

endmodule

// File: tb/tb_cic_d_mc.sv
// Randomized scoreboard bench for cic_d_mc; reference is a direct FIR convolution with the
// equivalent CIC impulse response, evaluated on every R-th sample of each channel.
module tb_cic_d_mc;

    localparam int unsigned CIC_N     = 3;
    localparam int unsigned CIC_M     = 1;
    localparam int unsigned CIC_R_MAX = 16;
    localparam int unsigned NUM_CH    = 2;
    localparam int unsigned CH_W      = 1;
    localparam int unsigned RATE_W    = 5;
    localparam int unsigned SHIFT_W   = 5;
    localparam int          LAT       = 2 * CIC_N + 1;
`ifdef CIC_D_MC_ROUND_EN
    localparam bit ROUND_EN = 1'b1;
`else
    localparam bit ROUND_EN = 1'b0;
`endif

    typedef struct {
        int     ch;
        longint y;
        longint edge_no;
    } exp_t;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [RATE_W-1:0]  cfg_rate = '0;
    logic [SHIFT_W-1:0] cfg_shift = '0;
    logic               cfg_load = 1'b0;
    logic signed [15:0] s_axis_in_tdata = '0;
    logic [CH_W-1:0]    s_axis_in_tuser = '0;
    logic               s_axis_in_tvalid = 1'b0;
    logic signed [15:0] m_axis_out_tdata;
    logic [CH_W-1:0]    m_axis_out_tuser;
    logic               m_axis_out_tvalid;

    int     n_tests = 0;
    int     n_fail  = 0;
    longint edge_cnt = 0;
    exp_t   sb[$];
    int     out_cnt [NUM_CH];
    longint last_out [NUM_CH];

    longint hist [NUM_CH][$];
    int     cnt_m [NUM_CH];
    int     rate_m = 1;
    int     shift_m = 0;
    longint h[$];

    cic_d_mc dut (
        .clk               (clk),
        .reset             (reset),
        .cfg_rate          (cfg_rate),
        .cfg_shift         (cfg_shift),
        .cfg_load          (cfg_load),
        .s_axis_in_tdata   (s_axis_in_tdata),
        .s_axis_in_tuser   (s_axis_in_tuser),
        .s_axis_in_tvalid  (s_axis_in_tvalid),
        .m_axis_out_tdata  (m_axis_out_tdata),
        .m_axis_out_tuser  (m_axis_out_tuser),
        .m_axis_out_tvalid (m_axis_out_tvalid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // impulse response of N cascaded length-(R*M) boxcars
    function automatic void build_h();
        longint nxt[$];
        int     l;
        l = rate_m * CIC_M;
        h.delete();
        h.push_back(1);
        for (int s = 0; s < CIC_N; s++) begin
            nxt.delete();
            for (int i = 0; i < h.size() + l - 1; i++) nxt.push_back(0);
            for (int i = 0; i < h.size(); i++)
                for (int j = 0; j < l; j++) nxt[i+j] += h[i];
            h = nxt;
        end
    endfunction

    function automatic longint model_y(input int ch);
        longint a;
        a = 0;
        for (int i = 0; i < h.size() && i < hist[ch].size(); i++) a += h[i] * hist[ch][i];
        if (ROUND_EN && shift_m > 0) a += 64'sd1 <<< (shift_m - 1);
        a = a >>> shift_m;
        if (a > 32767) a = 32767;
        else if (a < -32768) a = -32768;
        return a;
    endfunction

    function automatic void model_flush();
        for (int c = 0; c < NUM_CH; c++) begin
            hist[c].delete();
            cnt_m[c] = 0;
        end
    endfunction

    function automatic void model_accept(input int ch, input logic signed [15:0] d);
        exp_t e;
        hist[ch].push_front(longint'(d));
        if (hist[ch].size() > 64) void'(hist[ch].pop_back());
        cnt_m[ch]++;
        if (cnt_m[ch] == rate_m) begin
            cnt_m[ch] = 0;
            e.ch      = ch;
            e.y       = model_y(ch);
            e.edge_no = edge_cnt + LAT;
            sb.push_back(e);
        end
    endfunction

    // drop expectations whose output register would be cleared by a flush issued now
    function automatic void purge();
        while (sb.size() > 0 && sb[sb.size()-1].edge_no > edge_cnt) void'(sb.pop_back());
    endfunction

    task automatic check(input string name, input longint act, input longint req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
        reset            = 1'b0;
        cfg_load         = 1'b0;
        s_axis_in_tvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic send(input int ch, input logic signed [15:0] d);
        @(posedge clk);
        #2;
        reset            = 1'b0;
        cfg_load         = 1'b0;
        s_axis_in_tvalid = 1'b1;
        s_axis_in_tuser  = CH_W'(ch);
        s_axis_in_tdata  = d;
        model_accept(ch, d);
    endtask

    // a sample is presented on the load cycle on purpose; it must be discarded
    task automatic load(input int r, input int s);
        @(posedge clk);
        #2;
        reset            = 1'b0;
        cfg_load         = 1'b1;
        cfg_rate         = RATE_W'(r);
        cfg_shift        = SHIFT_W'(s);
        s_axis_in_tvalid = 1'b1;
        s_axis_in_tuser  = CH_W'($urandom_range(0, 1));
        s_axis_in_tdata  = 16'($urandom);
        purge();
        model_flush();
        rate_m  = (r == 0) ? 1 : (r > int'(CIC_R_MAX)) ? int'(CIC_R_MAX) : r;
        shift_m = s;
        build_h();
        for (int c = 0; c < NUM_CH; c++) out_cnt[c] = 0;
    endtask

    task automatic do_reset(input int cycles);
        @(posedge clk);
        #2;
        reset            = 1'b1;
        cfg_load         = 1'b0;
        s_axis_in_tvalid = 1'b1;
        s_axis_in_tdata  = 16'($urandom);
        purge();
        model_flush();
        rate_m  = 1;
        shift_m = 0;
        build_h();
        @(posedge clk);
        #2;
        check("reset_tvalid", longint'(m_axis_out_tvalid), 0);
        check("reset_tdata", longint'(m_axis_out_tdata), 0);
        check("reset_tuser", longint'(m_axis_out_tuser), 0);
        repeat (cycles - 1) @(posedge clk);
        for (int c = 0; c < NUM_CH; c++) out_cnt[c] = 0;
    endtask

    // monitor: every output must match the head of the scoreboard, including its cycle
    always @(negedge clk) begin
        exp_t e;
        if (m_axis_out_tvalid === 1'b1) begin
            out_cnt[m_axis_out_tuser]++;
            last_out[m_axis_out_tuser] = longint'(m_axis_out_tdata);
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output: got ch=%0d y=%0d at edge %0d, required no output",
                         m_axis_out_tuser, m_axis_out_tdata, edge_cnt);
            end else begin
                e = sb.pop_front();
                if (int'(m_axis_out_tuser) != e.ch || longint'(m_axis_out_tdata) != e.y ||
                    edge_cnt != e.edge_no) begin
                    n_fail++;
                    $display("FAIL out_sample: got ch=%0d y=%0d edge=%0d, required ch=%0d y=%0d edge=%0d",
                             m_axis_out_tuser, m_axis_out_tdata, edge_cnt, e.ch, e.y, e.edge_no);
                end
            end
        end
    end

    initial begin
        for (int c = 0; c < NUM_CH; c++) begin
            out_cnt[c]  = 0;
            last_out[c] = 0;
        end
        build_h();
        do_reset(3);

        // channel isolation: +100 / -50 interleaved every cycle
        load(4, 0);
        for (int i = 0; i < 100; i++) begin
            send(0, 16'sd100);
            send(1, -16'sd50);
        end
        idle(10);
        check("iso_ch0_value", last_out[0], 6400);
        check("iso_ch1_value", last_out[1], -3200);
        check("iso_ch0_count", out_cnt[0], 25);
        check("iso_ch1_count", out_cnt[1], 25);

        // impulse response and latency
        load(4, 0);
        send(0, 16'sd1);
        for (int i = 0; i < 23; i++) send(0, 16'sd0);
        idle(10);
        check("impulse_count", out_cnt[0], 6);

        // saturation both rails
        load(4, 0);
        for (int i = 0; i < 40; i++) send(0, 16'sd32767);
        idle(10);
        check("sat_pos", last_out[0], 32767);
        for (int i = 0; i < 40; i++) send(0, -16'sd32768);
        idle(10);
        check("sat_neg", last_out[0], -32768);

        // rate change with flush while results are in flight
        load(4, 0);
        for (int i = 0; i < 40; i++) send($urandom_range(0, 1), 16'($urandom));
        load(8, 9);
        for (int i = 0; i < 7; i++) send(0, 16'sd1000);
        idle(10);
        check("flush_no_early_output", out_cnt[0], 0);
        for (int i = 0; i < 57; i++) send(0, 16'sd1000);
        idle(10);
        check("rate8_steady", last_out[0], 1000);

        // rounding of an exact half
        load(4, 7);
        for (int i = 0; i < 40; i++) send(1, 16'sd1);
        idle(10);
        check("round_half", last_out[1], ROUND_EN ? 1 : 0);

        // mid-frame reset, then rate register back to 1
        load(4, 0);
        for (int i = 0; i < 6; i++) send(0, 16'($urandom));
        do_reset(2);
        send(0, 16'sd77);
        idle(10);
        check("post_reset_rate1", out_cnt[0], 1);
        load(4, 0);
        for (int i = 0; i < 3; i++) send(0, 16'sd5);
        idle(10);
        check("fresh_r_wait", out_cnt[0], 0);
        send(0, 16'sd5);
        idle(10);
        check("fresh_r_output", out_cnt[0], 1);

        // clamped rates and random traffic with gaps
        for (int r = 0; r < 6; r++) begin
            load((r == 0) ? 0 : (r == 1) ? 31 : $urandom_range(0, 31), $urandom_range(0, 20));
            for (int i = 0; i < 300; i++) begin
                if ($urandom_range(0, 3) == 0) step();
                else send($urandom_range(0, 1), 16'($urandom));
            end
        end

        idle(12);
        check("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
